// File: rtl/led_pattern_ctrl.sv
// Single-touch LED pattern controller.
// A debounced touch pad drives a small press FSM: a short press pauses or
// resumes the pattern, a long press advances to the next pattern. Three PWM
// patterns are available: unison breathing, chase, and anti-phase wave.
module led_pattern_ctrl #(
  parameter int LED_NUM     = 4,
  parameter int DEB_MAX     = 500000,
  parameter int PWM_MAX     = 100,
  parameter int STEP_FRAMES = 100,
  parameter int LONG_MAX    = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               touch,
  output logic [LED_NUM-1:0] led,
  output logic [1:0]         mode,
  output logic               paused
);

  // Counter widths; a width never drops below one bit for degenerate maxima.
  localparam int DEB_W   = (DEB_MAX > 1)     ? $clog2(DEB_MAX)     : 1;
  localparam int HOLD_W  = (LONG_MAX > 1)    ? $clog2(LONG_MAX)    : 1;
  localparam int PWM_W   = (PWM_MAX > 1)     ? $clog2(PWM_MAX)     : 1;
  localparam int DUTY_W  = $clog2(PWM_MAX + 1);
  localparam int FRAME_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int IDX_W   = $clog2(LED_NUM);

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_MAX - 1);
  localparam logic [HOLD_W-1:0]  LONG_LAST  = HOLD_W'(LONG_MAX - 1);
  localparam logic [PWM_W-1:0]   PWM_LAST   = PWM_W'(PWM_MAX - 1);
  localparam logic [DUTY_W-1:0]  DUTY_FULL  = DUTY_W'(PWM_MAX);
  localparam logic [DUTY_W-1:0]  DUTY_TOP   = DUTY_W'(PWM_MAX - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(STEP_FRAMES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(LED_NUM - 1);

  typedef enum logic [1:0] {
    MODE_BREATHE = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_WAVE    = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_HELD,
    P_SHORT,
    P_LONG
  } press_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0]       sync_q;
  logic             touch_s;
  logic             btn_level;
  logic [DEB_W-1:0] deb_cnt;

  assign touch_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous touch pad.
  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware shift chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[0], touch};
  end

  // Debounce: the level only follows touch_s after it has differed for DEB_MAX cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else if (touch_s == btn_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_level <= touch_s;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Press classification
  // ---------------------------------------------------------------------------
  press_e            press_q, press_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic              short_p, long_p;

  // Press FSM state and hold counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_q  <= P_IDLE;
      hold_cnt <= '0;
    end else begin
      press_q  <= press_d;
      hold_cnt <= hold_d;
    end
  end

  // Press FSM next state; long_p fires on the transition into LONG, short_p
  // is the one cycle spent in SHORT, so the two can never coincide.
  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    press_d = press_q;
    hold_d  = '0;
    long_p  = 1'b0;
    case (press_q)
      P_IDLE:  if (btn_level) press_d = P_HELD;
      P_HELD: begin
        if (!btn_level) begin
          press_d = P_SHORT;
        end else if (hold_cnt == LONG_LAST) begin
          long_p  = 1'b1;
          press_d = P_LONG;
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      P_SHORT: press_d = P_IDLE;
      P_LONG:  if (!btn_level) press_d = P_IDLE;
      default: press_d = P_IDLE;
    endcase
  end

  assign short_p = (press_q == P_SHORT);

  // ---------------------------------------------------------------------------
  // Mode and pause control
  // ---------------------------------------------------------------------------
  mode_e mode_q;

  assign mode = mode_q;

  // Short press toggles pause; long press advances the mode and always resumes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_BREATHE;
      paused <= 1'b0;
    end else if (long_p) begin
      paused <= 1'b0;
      case (mode_q)
        MODE_BREATHE: mode_q <= MODE_CHASE;
        MODE_CHASE:   mode_q <= MODE_WAVE;
        default:      mode_q <= MODE_BREATHE;
      endcase
    end else if (short_p) begin
      paused <= ~paused;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern engine
  // ---------------------------------------------------------------------------
  logic [PWM_W-1:0]   pwm_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic [DUTY_W-1:0]  duty;
  dir_e               dir;
  logic [IDX_W-1:0]   chase_idx;
  logic               frame_end, step;

  assign frame_end = (pwm_cnt == PWM_LAST);
  assign step      = frame_end && (frame_cnt == FRAME_LAST);

  // PWM/frame counters and the triangular duty ramp; a long press restarts
  // the pattern from zero, a pause freezes it in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt   <= '0;
      frame_cnt <= '0;
      duty      <= '0;
      dir       <= DIR_UP;
      chase_idx <= '0;
    end else if (long_p) begin
      pwm_cnt   <= '0;
      frame_cnt <= '0;
      duty      <= '0;
      dir       <= DIR_UP;
      chase_idx <= '0;
    end else if (!paused) begin
      pwm_cnt <= frame_end ? '0 : pwm_cnt + 1'b1;
      if (frame_end) frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
      if (step) begin
        if (dir == DIR_UP) begin
          duty <= duty + 1'b1;
          if (duty == DUTY_TOP) begin
            dir       <= DIR_DOWN;
            chase_idx <= (chase_idx == IDX_LAST) ? '0 : chase_idx + 1'b1;
          end
        end else begin
          duty <= duty - 1'b1;
          if (duty == DUTY_W'(1)) begin
            dir       <= DIR_UP;
            chase_idx <= (chase_idx == IDX_LAST) ? '0 : chase_idx + 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // LED decode
  // ---------------------------------------------------------------------------
  logic [DUTY_W-1:0]  pwm_ext;
  logic               breathe_on, anti_on;
  logic [LED_NUM-1:0] led_d;

  assign pwm_ext    = DUTY_W'(pwm_cnt);
  assign breathe_on = (pwm_ext < duty);
  assign anti_on    = (pwm_ext < (DUTY_FULL - duty));

  // Per-mode LED pattern; the unused mode encoding falls back to breathing.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < LED_NUM; i++) begin
      case (mode_q)
        MODE_CHASE: led_d[i] = (chase_idx == IDX_W'(i));
        MODE_WAVE:  led_d[i] = (i % 2 == 0) ? breathe_on : anti_on;
        default:    led_d[i] = breathe_on;
      endcase
    end
  end

  // Registered LED drive, held while paused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       led <= '0;
    else if (!paused) led <= led_d;
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl with small timing parameters.
// Stimulus pushes time-tagged expectations; a monitor samples 1 ns after each
// rising edge and compares every expectation that falls due on that cycle.
module tb_led_pattern_ctrl;

  localparam int LED_NUM     = 4;
  localparam int DEB_MAX     = 4;
  localparam int PWM_MAX     = 4;
  localparam int STEP_FRAMES = 2;
  localparam int LONG_MAX    = 20;
  localparam int STEP_CYC    = PWM_MAX * STEP_FRAMES;   // cycles per duty step
  localparam int CHASE_CYC   = STEP_CYC * PWM_MAX;      // cycles per chase move

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic               touch = 1'b0;
  logic [LED_NUM-1:0] led;
  logic [1:0]         mode;
  logic               paused;

  led_pattern_ctrl #(
    .LED_NUM    (LED_NUM),
    .DEB_MAX    (DEB_MAX),
    .PWM_MAX    (PWM_MAX),
    .STEP_FRAMES(STEP_FRAMES),
    .LONG_MAX   (LONG_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .touch (touch),
    .led   (led),
    .mode  (mode),
    .paused(paused)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         at;
    bit         chk_led;
    logic [3:0] led;
    bit         chk_mode;
    logic [1:0] mode;
    bit         chk_paused;
    logic       paused;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(string name, logic [7:0] act, logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_at(string nm, int at, bit cl, logic [3:0] l,
                           bit cm, logic [1:0] md, bit cp, logic p);
    exp_t e;
    e.name = nm; e.at = at;
    e.chk_led = cl; e.led = l;
    e.chk_mode = cm; e.mode = md;
    e.chk_paused = cp; e.paused = p;
    sb.push_back(e);
  endtask

  // Reference pattern: triangular duty ramp over state index j (cycles since restart).
  function automatic int duty_of(int j);
    int s;
    s = (j / STEP_CYC) % (2 * PWM_MAX);
    return (s <= PWM_MAX) ? s : 2 * PWM_MAX - s;
  endfunction

  function automatic logic [3:0] breathe_led(int j);
    return ((j % PWM_MAX) < duty_of(j)) ? 4'hF : 4'h0;
  endfunction

  function automatic logic [3:0] wave_led(int j);
    logic a, b;
    a = ((j % PWM_MAX) < duty_of(j));
    b = ((j % PWM_MAX) < (PWM_MAX - duty_of(j)));
    return {b, a, b, a};
  endfunction

  function automatic logic [3:0] chase_led(int j);
    logic [3:0] one;
    one = 4'b0001;
    return one << ((j / CHASE_CYC) % LED_NUM);
  endfunction

  // Monitor: compare everything due on this cycle, away from the clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", sb[i].name, sb[i].at, cyc);
          sb.delete(i);
        end else if (sb[i].at == cyc) begin
          if (sb[i].chk_led)    check({sb[i].name, " led"},    {4'h0, led},    {4'h0, sb[i].led});
          if (sb[i].chk_mode)   check({sb[i].name, " mode"},   {6'h0, mode},   {6'h0, sb[i].mode});
          if (sb[i].chk_paused) check({sb[i].name, " paused"}, {7'h0, paused}, {7'h0, sb[i].paused});
          sb.delete(i);
        end
      end
    end
  end

  task automatic step_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int len);
    touch = 1'b1;
    step_n(len);
    touch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int off, c, d, e, s, e2, e3, e4, h;
    logic [3:0] lfrz;

    // Reset state.
    reset = 1'b0;
    for (int m = 1; m <= 3; m++) expect_at("reset", m, 1, 4'h0, 1, 2'd0, 1, 1'b0);
    step_n(3);
    reset = 1'b1;
    off = cyc + 1;

    // Breathing from reset: dark for the first step, full on after four steps.
    for (int m = cyc + 1; m <= cyc + 48; m++)
      expect_at("breathe", m, 1, breathe_led(m - off), 1, 2'd0, 1, 1'b0);
    step_n(48);

    // Glitch rejection: 3-cycle pulses never reach the debounced level.
    for (int m = cyc + 1; m <= cyc + 34; m++)
      expect_at("glitch", m, 1, breathe_led(m - off), 1, 2'd0, 1, 1'b0);
    press(3);
    step_n(3);
    repeat (3) begin
      press(3);
      step_n(3);
    end
    step_n(10);

    // Short press: pause two cycles after the debounced release, LEDs frozen.
    c = cyc;
    lfrz = breathe_led(c + 18 - off);
    for (int m = c + 1; m <= c + 17; m++)
      expect_at("short1 run", m, 1, breathe_led(m - off), 1, 2'd0, 1, 1'b0);
    for (int m = c + 18; m <= c + 117; m++)
      expect_at("short1 frozen", m, 1, lfrz, 1, 2'd0, 1, 1'b1);
    press(10);
    step_n(108);

    // Second short press: resume from the frozen point.
    d = cyc;
    for (int m = d + 1; m <= d + 17; m++)
      expect_at("short2 frozen", m, 1, lfrz, 1, 2'd0, 1, 1'b1);
    off = off + (d - c);
    for (int m = d + 18; m <= d + 57; m++)
      expect_at("short2 resume", m, 1, breathe_led(m - off), 1, 2'd0, 1, 1'b0);
    press(10);
    step_n(48);

    // Long press 1: mode 0 -> 1 exactly LONG_MAX+1 cycles after the debounced rise.
    e = cyc;
    expect_at("long1 before", e + 26, 0, 4'h0, 1, 2'd0, 1, 1'b0);
    expect_at("long1 edge",   e + 27, 0, 4'h0, 1, 2'd1, 1, 1'b0);
    for (int m = e + 28; m <= e + 60; m++)
      expect_at("long1 chase", m, 1, chase_led(m - e - 28), 1, 2'd1, 1, 1'b0);
    press(40);
    step_n(20);

    // Short press in CHASE: pause and freeze.
    s = cyc;
    for (int m = s + 1; m <= s + 17; m++)
      expect_at("short3 run", m, 1, chase_led(m - e - 28), 1, 2'd1, 1, 1'b0);
    lfrz = chase_led(s + 18 - e - 28);
    for (int m = s + 18; m <= s + 25; m++)
      expect_at("short3 frozen", m, 1, lfrz, 1, 2'd1, 1, 1'b1);
    press(10);
    step_n(15);

    // Long press 2 while paused: mode 1 -> 2, pause cleared, WAVE from a fresh start.
    e2 = cyc;
    for (int m = e2 + 1; m <= e2 + 26; m++)
      expect_at("long2 held", m, 1, lfrz, 1, 2'd1, 1, 1'b1);
    expect_at("long2 edge", e2 + 27, 1, lfrz, 1, 2'd2, 1, 1'b0);
    for (int m = e2 + 28; m <= e2 + 107; m++)
      expect_at("wave", m, 1, wave_led(m - e2 - 28), 1, 2'd2, 1, 1'b0);
    press(40);
    step_n(68);

    // Long press 3: mode 2 -> 0.
    e3 = cyc;
    expect_at("long3 before", e3 + 26, 0, 4'h0, 1, 2'd2, 0, 1'b0);
    expect_at("long3 edge",   e3 + 27, 0, 4'h0, 1, 2'd0, 1, 1'b0);
    expect_at("long3 after",  e3 + 50, 0, 4'h0, 1, 2'd0, 1, 1'b0);
    press(40);
    step_n(10);

    // Long press 4: mode 0 -> 1, then a full chase lap including the wrap.
    e4 = cyc;
    expect_at("long4 before", e4 + 26, 0, 4'h0, 1, 2'd0, 0, 1'b0);
    expect_at("long4 edge",   e4 + 27, 0, 4'h0, 1, 2'd1, 1, 1'b0);
    for (int m = e4 + 28; m <= e4 + 170; m++)
      expect_at("chase", m, 1, chase_led(m - e4 - 28), 1, 2'd1, 1, 1'b0);
    press(40);
    step_n(130);

    // Reset during a hold: outputs clear at once, the press is discarded.
    h = cyc;
    touch = 1'b1;
    step_n(8);
    reset = 1'b0;
    #1;
    check("async reset led",    {4'h0, led},    8'h00);
    check("async reset mode",   {6'h0, mode},   8'h00);
    check("async reset paused", {7'h0, paused}, 8'h00);
    for (int m = h + 9; m <= h + 18; m++)
      expect_at("in reset", m, 1, 4'h0, 1, 2'd0, 1, 1'b0);
    step_n(7);
    touch = 1'b0;
    step_n(3);
    reset = 1'b1;
    off = cyc + 1;
    for (int m = cyc + 1; m <= cyc + 42; m++)
      expect_at("after reset", m, 1, breathe_led(m - off), 1, 2'd0, 1, 1'b0);
    step_n(42);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Parametrised single-touch LED pattern controller. It drives `LED_NUM` LEDs with PWM in three selectable patterns: unison breathing, chase, and anti-phase wave. A short press pauses or resumes the pattern; a long press advances the mode. It sits at top level between the board touch pad and the LED pins, and folds debounce, pause control and gradual lighting into one block.

## Interface
Parameters:
- `LED_NUM`, 4: number of LED channels; minimum 2.
- `DEB_MAX`, 500000: cycles `touch` must stay stable before the debounced level changes.
- `PWM_MAX`, 100: PWM period in cycles. Duty ranges 0..`PWM_MAX`.
- `STEP_FRAMES`, 100: PWM periods per duty step.
- `LONG_MAX`, 50000000: cycles held before a long press is declared.

Ports:
- `clk`, input, 1: single system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `touch`, input, 1: raw touch pad; asynchronous and bouncy.
- `led`, output, `LED_NUM`: LED drive, 1 = on.
- `mode`, output, 2: current pattern. 0 = BREATHE, 1 = CHASE, 2 = WAVE.
- `paused`, output, 1: 1 while the pattern is frozen.

Counter widths are derived with `$clog2` of the relevant maximum.

## Operation
- **Reset state.** `led`=0, `mode`=0, `paused`=0, `duty`=0, `dir`=up, `chase_idx`=0. All counters are 0 and the press FSM is in IDLE.
- **Sync.** `touch` passes through 2 flops to give `touch_s`.
- **Debounce.**
  - If `touch_s`==`btn_level`, `deb_cnt` is cleared.
  - Otherwise `deb_cnt` increments. When it reaches `DEB_MAX-1`, `btn_level` takes `touch_s` and `deb_cnt` is cleared.
  - Pulses shorter than `DEB_MAX` cycles are ignored.
- **Press FSM.**
  - IDLE: rising edge of `btn_level` → HELD, `hold_cnt`=0.
  - HELD: `hold_cnt` increments.
    - Falling edge → 1-cycle `short_p`, then IDLE.
    - `hold_cnt`==`LONG_MAX-1` → 1-cycle `long_p`, then LONG.
  - LONG: falling edge → IDLE. No pulse is generated.
- **`short_p`:** `paused` toggles.
- **`long_p`:**
  - `mode` advances 0→1→2→0.
  - `paused` is forced to 0.
  - The pattern engine restarts: `pwm_cnt`, `frame_cnt`, `duty` and `chase_idx` go to 0, and `dir` goes to up.
- **Pattern engine.** All of the following hold their values while `paused`=1, including `led`.
  - `pwm_cnt` counts 0..`PWM_MAX-1` and wraps; `frame_end` = (`pwm_cnt`==`PWM_MAX-1`).
  - `frame_cnt` counts 0..`STEP_FRAMES-1`; `step` = `frame_end` && `frame_cnt`==`STEP_FRAMES-1`.
  - On `step`, with `dir` up: `duty`+1. When it reaches `PWM_MAX`, `dir` becomes down.
  - On `step`, with `dir` down: `duty`−1. When it reaches 0, `dir` becomes up.
  - Each reversal step advances `chase_idx`, wrapping `LED_NUM-1`→0.
- **Per-mode LED output.** `led` is registered from the following:
  - BREATHE: `led[i]` = (`pwm_cnt` < `duty`) for all `i`.
  - CHASE: `led[i]` = (`i`==`chase_idx`).
  - WAVE: `led[i]` = (`pwm_cnt` < `duty`) for even `i`, and (`pwm_cnt` < `PWM_MAX-duty`) for odd `i`.
  - `mode`=3 is unreachable and decodes as BREATHE.
- **Boundary behaviour.**
  - `duty`=0 gives the LED fully off; `duty`=`PWM_MAX` gives it fully on.
  - A long press while paused resumes the pattern.
  - A press in progress during reset is discarded.
  - `short_p` and `long_p` are mutually exclusive.

## Timing
- `touch` edge to `btn_level` change: 2 + `DEB_MAX` cycles, for stable input.
- `btn_level` fall to `paused` toggle: 1 cycle after `short_p`, i.e. 2 cycles.
- `btn_level` rise to `mode` change: `LONG_MAX` + 1 cycles.
- `led` lags the counters by 1 cycle.
- Breathing period: 2·`PWM_MAX`·`STEP_FRAMES`·`PWM_MAX` cycles.
- CHASE moves one position every `PWM_MAX`·`STEP_FRAMES`·`PWM_MAX` cycles.
- `reset` low clears every flop immediately, without waiting for a clock edge.

## Test plan
Bench parameters: `LED_NUM`=4, `DEB_MAX`=4, `PWM_MAX`=4, `STEP_FRAMES`=2, `LONG_MAX`=20.
- **Reset and breathing.** Assert `reset` low, then release → `led`=0, `mode`=0, `paused`=0. `led[3:0]` is all-equal, first high after 8 cycles, and reaches 100% on-time after 4 steps (32 cycles).
- **Glitch rejection.** Pulse `touch` high for 3 cycles, and 3-cycle bursts alternating → `paused` and `mode` never change.
- **Short press.** Hold `touch` 10 cycles, then release → `paused`=1 and `led` is frozen for 100 cycles. Repeat the press → `paused`=0 and counting resumes from the frozen values.
- **Long press.** Hold `touch` 40 cycles → exactly one `mode` increment, 0→1, and `paused` cleared; release causes no further change. Three more long presses → `mode` goes 2, 0, 1.
- **CHASE.** In mode 1 → `led`=0001, then 0010 after 32 cycles, then 0100, 1000, then 0001 (wrap).
- **WAVE and reset mid-hold.** In mode 2, `led[0]` and `led[1]` on-times per PWM period sum to 4. Assert `reset` low during a 15-cycle hold → all outputs 0, and no `mode` change after release.
